// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between a core's instruction-fetch
// port (i_*) and its data port (d_*). One transaction is outstanding at a
// time. When both ports are pending, grants alternate round-robin. Every
// memory-side output is a flop.
//
// Handshake (both requester ports and the memory port):
//   - A requester raises x_req and holds it, with its fields, until x_done.
//   - x_done is a one-cycle pulse. In the cycle it pulses, x_req is ignored,
//     so a back-to-back request is granted one cycle later.
//   - mem_req is held until mem_ack. mem_ack is a one-cycle pulse and
//     mem_rdata is valid in that cycle. An ack while mem_req is low is
//     ignored.
//
// Ports:
//   clk, rst                 clock (rising edge); async active-high reset
//   i_req, i_addr            fetch request in
//   i_done, i_rdata          fetch completion out; i_rdata is held
//   d_req, d_we, d_addr,
//   d_wdata, d_mode          data request in (load or store)
//   d_done, d_rdata          data completion out; d_rdata is held, and
//                            is updated by loads only
//   core_stall               combinational stall for the core pipeline
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_mode      registered memory request out
//   mem_ack, mem_rdata       memory response in
//   bus_err                  pulses together with done on a timed-out access
//   dbg_state                current FSM state (0 IDLE, 1 BUSY_I, 2 BUSY_D)
//
// Optional feature, macro MEM_ARB_TIMEOUT_EN:
//   A transaction is aborted after TIMEOUT_CYCLES busy cycles that see no ack.
//   A fetch then returns a NOP, and a load returns 0. Without the macro, the
//   arbiter waits for mem_ack indefinitely and bus_err is tied low.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MODE_WIDTH     = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_done,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [MODE_WIDTH-1:0] d_mode,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  core_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MODE_WIDTH-1:0] mem_mode,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  bus_err,
  output logic [1:0]            dbg_state
);

  localparam logic [MODE_WIDTH-1:0] MODE_WORD = MODE_WIDTH'(2'b10);
  localparam logic [DATA_WIDTH-1:0] NOP_INSN  = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_d_q, last_d_d;   // 1: the last grant went to D
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [MODE_WIDTH-1:0] mem_mode_q, mem_mode_d;
  logic                  i_done_q, i_done_d;
  logic                  d_done_q, d_done_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  i_elig, d_elig, pick_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             expired;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mode_d  = mem_mode_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    // A port whose done is pulsing this cycle is not requesting again yet.
    i_elig      = i_req & ~i_done_q;
    d_elig      = d_req & ~d_done_q;
    // D wins if it is alone, or if both are eligible and I had the last turn.
    pick_d      = d_elig & (~i_elig | ~last_d_q);
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    // The current edge is the TIMEOUT_CYCLES-th busy edge that sees no ack.
    expired   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
    unique case (state_q)
      IDLE: begin
        if (i_elig | d_elig) begin
          mem_req_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (pick_d) begin
            state_d     = BUSY_D;
            last_d_d    = 1'b1;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_mode_d  = d_mode;
          end else begin
            state_d     = BUSY_I;
            last_d_d    = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
            mem_mode_d  = MODE_WORD;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack always takes priority over a timeout in the same cycle.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = mem_rdata;
          end else begin
            d_done_d = 1'b1;
            if (!mem_we_q) d_rdata_d = mem_rdata;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (expired) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          bus_err_d = 1'b1;
          if (state_q == BUSY_I) begin
            i_done_d  = 1'b1;
            i_rdata_d = NOP_INSN;
          end else begin
            d_done_d = 1'b1;
            if (!mem_we_q) d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mode_q  <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mode_q  <= mem_mode_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_mode   = mem_mode_q;
  assign i_done     = i_done_q;
  assign d_done     = d_done_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign dbg_state  = state_q;
  assign core_stall = (i_req & ~i_done_q) | (d_req & ~d_done_q);
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch port and its data port.
- Sits between the pipelined core and the memory; the core gains a stall input driven by `core_stall`.
- Grants one requester at a time: round-robin when both are pending, at most one transaction outstanding.
- All memory-side outputs are registered.

Parameters:
- ADDR_WIDTH, 32, width of the address on both requester ports and on the memory port.
- DATA_WIDTH, 32, width of instruction and data words.
- MODE_WIDTH, 2, width of the data-memory access mode field (byte/half/word).
- TIMEOUT_CYCLES, 255, used only with MEM_ARB_TIMEOUT_EN: cycles without `mem_ack` before a transaction is aborted.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  instruction fetch request; level, held until `i_done`.
- i_addr  in  ADDR_WIDTH  fetch address.
- i_done  out  1  one-cycle pulse: fetch complete, `i_rdata` valid.
- i_rdata  out  DATA_WIDTH  fetched instruction, held until the next `i_done`.
- d_req  in  1  data request; level, held until `d_done`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_mode  in  MODE_WIDTH  access mode, passed through to memory.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_WIDTH  load data, held until the next load's `d_done`.
- core_stall  out  1  `(i_req & ~i_done) | (d_req & ~d_done)`; combinational.
- mem_req  out  1  memory request; held until `mem_ack`.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_mode  out  MODE_WIDTH  memory access mode; equals `MODE_WIDTH'b10` (word) for fetches.
- mem_ack  in  1  one-cycle acknowledge; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  memory read data.
- bus_err  out  1  one-cycle pulse together with `done` on a timed-out transaction.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE, `last_grant` = I.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_mode` = 0.
  - `i_done`, `d_done`, `bus_err` = 0.
  - `i_rdata`, `d_rdata` = 0.
  - Timeout counter = 0.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, request eligibility:
  - A request is eligible if `x_req` = 1 and `x_done` = 0 in that cycle.
  - Consequence: a requester's req is ignored in the cycle its done pulses.
- IDLE, grant selection:
  - Only one eligible → grant it.
  - Both eligible → grant the one opposite to `last_grant`.
- IDLE, on grant, at the next edge:
  - Go to BUSY_x and set `last_grant` = x.
  - Set `mem_req` = 1 and latch address, we, wdata and mode.
  - For a fetch: `mem_we` = 0, `mem_wdata` = 0, mode = word.
- BUSY_x: the latched fields are frozen; changes on requester inputs are ignored.
- BUSY_x with `mem_ack` = 1, at the edge:
  - `mem_req` → 0, state → IDLE, `x_done` → 1 for one cycle.
  - `x_rdata` ← `mem_rdata`, except on a store: `d_rdata` is unchanged.
- Latency: req high in cycle 0 (IDLE) → `mem_req` in cycle 1 → earliest ack in cycle 1 → done in cycle 2.
  - Back-to-back from one requester: a new grant at the earliest in the cycle after done.
- `mem_ack` while `mem_req` = 0 (IDLE, or a late ack after reset) is ignored.
- Requester drops req while BUSY (protocol violation): the transaction still completes and done still pulses.
- `i_done` and `d_done` are never both 1.
- Reset mid-transaction: `mem_req` falls immediately (asynchronously); no done pulse is generated.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle with `mem_ack` = 0.
  - When it reaches TIMEOUT_CYCLES, at that edge: `mem_req` → 0, state → IDLE, `x_done` = 1, `bus_err` = 1 (one cycle).
  - Rdata on timeout: `i_rdata` = 32'h00000013 (NOP); `d_rdata` = 0 on a load.
  - An ack arriving in the same cycle as expiry wins: a normal completion with `bus_err` = 0.
- Not defined: no counter; `bus_err` is tied to 0; the arbiter waits for `mem_ack` indefinitely.

Test Plan:
- Single fetch:
  - Stimulus: `i_req`=1, `i_addr`=32'h100; memory acks 2 cycles after `mem_req` with 32'h00500093.
  - Response: `mem_addr`=32'h100, `mem_we`=0, `mem_mode`=2'b10; `i_done` 1 cycle after ack; `i_rdata`=32'h00500093; `core_stall`=1 until `i_done`.
- Simultaneous requests, from reset:
  - Stimulus: `i_req` and `d_req` both held from reset; d is a load from 32'h2000; zero-wait acks.
  - Response: D is granted first, then I; `i_done` and `d_done` never coincide; grants alternate D,I,D,I while both stay high.
- Store:
  - Stimulus: `d_we`=1, `d_addr`=32'h40, `d_wdata`=32'hCAFEF00D, `d_mode`=2'b00.
  - Response: memory sees exactly those values; `d_rdata` keeps its prior value (32'h0 after reset); `d_done` pulses once.
- Input changes and spurious acks:
  - Stimulus: `d_addr` changes while BUSY_D; a spurious `mem_ack` arrives in IDLE.
  - Response: `mem_addr` holds the latched value; the spurious ack causes no done and no state change.
- Reset mid-transaction:
  - Stimulus: `rst` asserted while BUSY_I with `mem_req`=1.
  - Response: `mem_req`=0 immediately; no `i_done`; state IDLE after reset release.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: fetch issued, memory never acks.
  - Response: after 4 BUSY cycles, `i_done`=`bus_err`=1 for one cycle and `i_rdata`=32'h00000013.
  - Repeat with the ack on cycle 4: normal completion, `bus_err`=0.
